// File: rtl/network_interface.sv
// Node network interface: buffers core packets toward router port 0 and ejects router packets to the core.
// Optional NI_THROTTLE_EN enforces at least INJECT_GAP cycles between successive injections.
package network_interface_pkg;
  typedef struct packed {
    logic [3:0]  x_dest;
    logic [3:0]  y_dest;
    logic [23:0] payload;
  } packet_t;
endpackage

module network_interface
  import network_interface_pkg::*;
#(
  parameter int X_LOC        = 0,
  parameter int Y_LOC        = 0,
  parameter int INJECT_DEPTH = 4,
  parameter int EJECT_DEPTH  = 4,
  parameter int CNT_W        = 16,
  parameter int INJECT_GAP   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  packet_t          i_core_data,
  input  logic             i_core_data_val,
  output logic             o_core_ready,
  output packet_t          o_data,
  output logic             o_data_val,
  input  logic             i_en,
  input  packet_t          i_data,
  input  logic             i_data_val,
  output logic             o_en,
  output packet_t          o_core_data,
  output logic             o_core_data_val,
  input  logic             i_core_ready,
  output logic [CNT_W-1:0] o_inject_count,
  output logic [CNT_W-1:0] o_eject_count,
  output logic [CNT_W-1:0] o_misroute_count,
  output logic             o_misroute_err
);
  localparam int IPW = (INJECT_DEPTH > 1) ? $clog2(INJECT_DEPTH) : 1;
  localparam int IOW = $clog2(INJECT_DEPTH + 1);
  localparam int EPW = (EJECT_DEPTH > 1) ? $clog2(EJECT_DEPTH) : 1;
  localparam int EOW = $clog2(EJECT_DEPTH + 1);
  localparam int GW  = (INJECT_GAP > 1) ? $clog2(INJECT_GAP) : 1;
  localparam logic [3:0] X_ID = X_LOC[3:0];
  localparam logic [3:0] Y_ID = Y_LOC[3:0];

  if (INJECT_DEPTH < 2 || EJECT_DEPTH < 2) begin : g_bad_depth
    $error("network_interface: FIFO depths must be at least 2");
  end
  if (INJECT_GAP < 1) begin : g_bad_gap
    $error("network_interface: INJECT_GAP must be at least 1");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // ---------------- injection FIFO ----------------
  packet_t          inj_mem_reg [INJECT_DEPTH];
  logic [IPW-1:0]   inj_wr_ptr_reg, inj_rd_ptr_reg;
  logic [IOW-1:0]   inj_occ_reg, inj_occ_next;
  logic [INJECT_DEPTH-1:0] inj_we;
  logic             inj_push, inj_pop, permit;

  assign o_core_ready = (inj_occ_reg < IOW'(INJECT_DEPTH));
  assign inj_push     = i_core_data_val && o_core_ready;
  assign o_data_val   = (inj_occ_reg != '0) && i_en && permit;
  assign inj_pop      = o_data_val;
  assign o_data       = inj_mem_reg[inj_rd_ptr_reg];

  for (genvar gi = 0; gi < INJECT_DEPTH; gi++) begin : g_inj_we
    assign inj_we[gi] = inj_push && (inj_wr_ptr_reg == IPW'(gi));
  end

  always_comb begin
    inj_occ_next = inj_occ_reg;
    if (inj_push && !inj_pop)      inj_occ_next = inj_occ_reg + IOW'(1);
    else if (!inj_push && inj_pop) inj_occ_next = inj_occ_reg - IOW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < INJECT_DEPTH; i++) inj_mem_reg[i] <= '0;
      inj_wr_ptr_reg <= '0;
      inj_rd_ptr_reg <= '0;
      inj_occ_reg    <= '0;
      o_inject_count <= '0;
    end else begin
      for (int i = 0; i < INJECT_DEPTH; i++)
        if (inj_we[i]) inj_mem_reg[i] <= i_core_data;
      if (inj_push)
        inj_wr_ptr_reg <= (inj_wr_ptr_reg == IPW'(INJECT_DEPTH - 1)) ? '0 : inj_wr_ptr_reg + IPW'(1);
      if (inj_pop) begin
        inj_rd_ptr_reg <= (inj_rd_ptr_reg == IPW'(INJECT_DEPTH - 1)) ? '0 : inj_rd_ptr_reg + IPW'(1);
        o_inject_count <= sat_inc(o_inject_count);
      end
      inj_occ_reg <= inj_occ_next;
    end
  end

`ifdef NI_THROTTLE_EN
  // Gap counter reloads on every injection and blocks the next one until it drains to 0.
  logic [GW-1:0] gap_reg;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            gap_reg <= '0;
    else if (inj_pop)        gap_reg <= GW'(INJECT_GAP - 1);
    else if (gap_reg != '0)  gap_reg <= gap_reg - GW'(1);
  end
  assign permit = (gap_reg == '0);
`else
  assign permit = 1'b1;
`endif

  // ---------------- ejection FIFO ----------------
  packet_t          ej_mem_reg [EJECT_DEPTH];
  logic [EPW-1:0]   ej_wr_ptr_reg, ej_rd_ptr_reg;
  logic [EOW-1:0]   ej_occ_reg, ej_occ_next;
  logic [EJECT_DEPTH-1:0] ej_we;
  logic             ej_push, ej_pop, misroute;

  assign o_en            = (ej_occ_reg < EOW'(EJECT_DEPTH));
  // A valid arriving while full violates the router protocol and is dropped.
  assign ej_push         = i_data_val && o_en;
  assign o_core_data_val = (ej_occ_reg != '0);
  assign ej_pop          = o_core_data_val && i_core_ready;
  assign o_core_data     = ej_mem_reg[ej_rd_ptr_reg];
  assign misroute        = ej_push && ((i_data.x_dest != X_ID) || (i_data.y_dest != Y_ID));

  for (genvar gi = 0; gi < EJECT_DEPTH; gi++) begin : g_ej_we
    assign ej_we[gi] = ej_push && (ej_wr_ptr_reg == EPW'(gi));
  end

  always_comb begin
    ej_occ_next = ej_occ_reg;
    if (ej_push && !ej_pop)      ej_occ_next = ej_occ_reg + EOW'(1);
    else if (!ej_push && ej_pop) ej_occ_next = ej_occ_reg - EOW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < EJECT_DEPTH; i++) ej_mem_reg[i] <= '0;
      ej_wr_ptr_reg    <= '0;
      ej_rd_ptr_reg    <= '0;
      ej_occ_reg       <= '0;
      o_eject_count    <= '0;
      o_misroute_count <= '0;
      o_misroute_err   <= 1'b0;
    end else begin
      for (int i = 0; i < EJECT_DEPTH; i++)
        if (ej_we[i]) ej_mem_reg[i] <= i_data;
      if (ej_push)
        ej_wr_ptr_reg <= (ej_wr_ptr_reg == EPW'(EJECT_DEPTH - 1)) ? '0 : ej_wr_ptr_reg + EPW'(1);
      if (ej_pop) begin
        ej_rd_ptr_reg <= (ej_rd_ptr_reg == EPW'(EJECT_DEPTH - 1)) ? '0 : ej_rd_ptr_reg + EPW'(1);
        o_eject_count <= sat_inc(o_eject_count);
      end
      if (misroute) begin
        o_misroute_count <= sat_inc(o_misroute_count);
        o_misroute_err   <= 1'b1;
      end
      ej_occ_reg <= ej_occ_next;
    end
  end
endmodule

// File: tb/tb_network_interface.sv
// Directed, table-driven bench for network_interface at node (1,2) with 4-entry FIFOs.
module tb_network_interface;
  import network_interface_pkg::*;

`ifdef NI_THROTTLE_EN
  localparam int GAP = 4;
`else
  localparam int GAP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  packet_t     i_core_data = '0;
  logic        i_core_data_val = 1'b0;
  logic        o_core_ready;
  packet_t     o_data;
  logic        o_data_val;
  logic        i_en = 1'b0;
  packet_t     i_data = '0;
  logic        i_data_val = 1'b0;
  logic        o_en;
  packet_t     o_core_data;
  logic        o_core_data_val;
  logic        i_core_ready = 1'b0;
  logic [15:0] o_inject_count, o_eject_count, o_misroute_count;
  logic        o_misroute_err;

  network_interface #(
    .X_LOC(1), .Y_LOC(2), .INJECT_DEPTH(4), .EJECT_DEPTH(4), .CNT_W(16), .INJECT_GAP(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_core_data(i_core_data), .i_core_data_val(i_core_data_val), .o_core_ready(o_core_ready),
    .o_data(o_data), .o_data_val(o_data_val), .i_en(i_en),
    .i_data(i_data), .i_data_val(i_data_val), .o_en(o_en),
    .o_core_data(o_core_data), .o_core_data_val(o_core_data_val), .i_core_ready(i_core_ready),
    .o_inject_count(o_inject_count), .o_eject_count(o_eject_count),
    .o_misroute_count(o_misroute_count), .o_misroute_err(o_misroute_err)
  );

  always #5 clk = ~clk;

  // The router must never present a valid while this node has o_en low.
  always @(posedge clk)
    if (reset_n) assert (!(i_data_val && !o_en)) else $error("protocol: i_data_val while o_en low");

  typedef struct {
    packet_t din; logic push; logic en;
    logic exp_ready; logic exp_val; packet_t exp_data; int exp_cnt;
  } inj_vec_t;

  typedef struct {
    packet_t din; logic dval; logic rdy;
    logic exp_en; logic exp_val; packet_t exp_data; int exp_ej; int exp_mis; logic exp_err;
  } ej_vec_t;

  inj_vec_t inj_tab[$];
  ej_vec_t  ej_tab[$];
  int applied = 0;
  int miscompares = 0;

  function automatic packet_t pk(input int x, input int y, input int pay);
    packet_t p;
    p.x_dest = 4'(x); p.y_dest = 4'(y); p.payload = 24'(pay);
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else
      $display("ok   %s = %0h", name, act);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic add_inj(input packet_t d, input logic push, input logic en,
                         input logic rdy, input logic val, input packet_t ed, input int cnt);
    inj_vec_t v;
    v.din = d; v.push = push; v.en = en;
    v.exp_ready = rdy; v.exp_val = val; v.exp_data = ed; v.exp_cnt = cnt;
    inj_tab.push_back(v);
  endtask

  task automatic add_ej(input packet_t d, input logic dval, input logic rdy, input logic en,
                        input logic val, input packet_t ed, input int ej, input int mis, input logic err);
    ej_vec_t v;
    v.din = d; v.dval = dval; v.rdy = rdy;
    v.exp_en = en; v.exp_val = val; v.exp_data = ed; v.exp_ej = ej; v.exp_mis = mis; v.exp_err = err;
    ej_tab.push_back(v);
  endtask

  initial begin
    packet_t a, b, c, d, e, f, p1, p2, p3, p4, m, t0, t1, t2, z;
    packet_t q[3];
    int pop_cyc[3];
    int n;

    a = pk(3, 0, 'hA1); b = pk(0, 1, 'hB2); c = pk(2, 2, 'hC3);
    d = pk(1, 3, 'hD4); e = pk(0, 0, 'hE5); f = pk(3, 3, 'hF6);
    p1 = pk(1, 2, 'h101); p2 = pk(1, 2, 'h202); p3 = pk(1, 2, 'h303); p4 = pk(1, 2, 'h404);
    m = pk(3, 2, 'hBAD); z = '0;

    // Injection: single packet, then fill to full with a refused 5th push that coincides with a pop.
    add_inj(a, 1, 1, 1, 0, z, 0);
    add_inj(z, 0, 1, 1, 1, a, 0);
    add_inj(z, 0, 1, 1, 0, z, 1);
    add_inj(b, 1, 0, 1, 0, z, 1);
    add_inj(c, 1, 0, 1, 0, z, 1);
    add_inj(d, 1, 0, 1, 0, z, 1);
    add_inj(e, 1, 0, 1, 0, z, 1);
    add_inj(f, 1, 0, 0, 0, z, 1);
    add_inj(f, 1, 1, 0, 1, b, 1);
    q[0] = c; q[1] = d; q[2] = e;
    for (int k = 0; k < 3; k++) begin
      for (int s = 1; s < GAP; s++) add_inj(z, 0, 1, 1, 0, z, 2 + k);
      add_inj(z, 0, 1, 1, 1, q[k], 2 + k);
    end
    add_inj(z, 0, 1, 1, 0, z, 5);

    // Ejection: fill with the core stalled, drain in order, then one misrouted packet.
    add_ej(p1, 1, 0, 1, 0, z, 0, 0, 0);
    add_ej(p2, 1, 0, 1, 1, p1, 0, 0, 0);
    add_ej(p3, 1, 0, 1, 1, p1, 0, 0, 0);
    add_ej(p4, 1, 0, 1, 1, p1, 0, 0, 0);
    add_ej(z, 0, 0, 0, 1, p1, 0, 0, 0);
    add_ej(z, 0, 1, 0, 1, p1, 0, 0, 0);
    add_ej(z, 0, 1, 1, 1, p2, 1, 0, 0);
    add_ej(z, 0, 1, 1, 1, p3, 2, 0, 0);
    add_ej(z, 0, 1, 1, 1, p4, 3, 0, 0);
    add_ej(z, 0, 1, 1, 0, z, 4, 0, 0);
    add_ej(m, 1, 1, 1, 0, z, 4, 0, 0);
    add_ej(z, 0, 1, 1, 1, m, 4, 1, 1);
    add_ej(z, 0, 1, 1, 0, z, 5, 1, 1);

    // Reset state while reset_n is held low.
    #2;
    chk("rst.core_ready", o_core_ready, 1);
    chk("rst.o_en", o_en, 1);
    chk("rst.data_val", o_data_val, 0);
    chk("rst.core_data_val", o_core_data_val, 0);
    chk("rst.o_data", o_data, 0);
    chk("rst.o_core_data", o_core_data, 0);
    chk("rst.counts", {o_inject_count, o_eject_count, o_misroute_count}, 0);
    chk("rst.err", o_misroute_err, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    foreach (inj_tab[i]) begin
      i_core_data = inj_tab[i].din; i_core_data_val = inj_tab[i].push; i_en = inj_tab[i].en;
      @(negedge clk);
      chk($sformatf("inj[%0d].core_ready", i), o_core_ready, inj_tab[i].exp_ready);
      chk($sformatf("inj[%0d].data_val", i), o_data_val, inj_tab[i].exp_val);
      if (inj_tab[i].exp_val) chk($sformatf("inj[%0d].data", i), o_data, inj_tab[i].exp_data);
      chk($sformatf("inj[%0d].inject_count", i), o_inject_count, 64'(inj_tab[i].exp_cnt));
      next_cycle();
    end
    i_core_data_val = 1'b0; i_en = 1'b0;

    foreach (ej_tab[i]) begin
      i_data = ej_tab[i].din; i_data_val = ej_tab[i].dval; i_core_ready = ej_tab[i].rdy;
      @(negedge clk);
      chk($sformatf("ej[%0d].o_en", i), o_en, ej_tab[i].exp_en);
      chk($sformatf("ej[%0d].core_val", i), o_core_data_val, ej_tab[i].exp_val);
      if (ej_tab[i].exp_val) chk($sformatf("ej[%0d].core_data", i), o_core_data, ej_tab[i].exp_data);
      chk($sformatf("ej[%0d].eject_count", i), o_eject_count, 64'(ej_tab[i].exp_ej));
      chk($sformatf("ej[%0d].misroute_count", i), o_misroute_count, 64'(ej_tab[i].exp_mis));
      chk($sformatf("ej[%0d].misroute_err", i), o_misroute_err, ej_tab[i].exp_err);
      next_cycle();
    end
    i_data_val = 1'b0; i_core_ready = 1'b0;

    // Asynchronous reset with traffic in both FIFOs.
    i_core_data = a; i_core_data_val = 1'b1; i_data = p1; i_data_val = 1'b1;
    next_cycle();
    i_core_data_val = 1'b0; i_data_val = 1'b0; i_en = 1'b1; i_core_ready = 1'b1;
    @(negedge clk);
    chk("pre_rst.data_val", o_data_val, 1);
    chk("pre_rst.core_val", o_core_data_val, 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst.data_val", o_data_val, 0);
    chk("async_rst.core_val", o_core_data_val, 0);
    chk("async_rst.counts", {o_inject_count, o_eject_count, o_misroute_count}, 0);
    chk("async_rst.err", o_misroute_err, 0);
    chk("async_rst.core_ready", o_core_ready, 1);
    chk("async_rst.o_en", o_en, 1);
    chk("async_rst.data", {o_data, o_core_data}, 0);
    i_en = 1'b0; i_core_ready = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Throttle spacing: three queued packets released with i_en held high.
    t0 = pk(1, 1, 'h7A0); t1 = pk(2, 1, 'h7A1); t2 = pk(0, 2, 'h7A2);
    q[0] = t0; q[1] = t1; q[2] = t2;
    for (int k = 0; k < 3; k++) begin
      i_core_data = q[k]; i_core_data_val = 1'b1;
      next_cycle();
    end
    i_core_data_val = 1'b0; i_en = 1'b1;
    n = 0;
    pop_cyc[0] = -100; pop_cyc[1] = -100; pop_cyc[2] = -100;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (o_data_val) begin
        if (n < 3) begin
          chk($sformatf("thr.pop%0d.data", n), o_data, q[n]);
          pop_cyc[n] = cyc;
        end
        n++;
      end
      next_cycle();
    end
    chk("thr.pop_total", 64'(n), 3);
    chk("thr.first_pop_cycle", 64'(pop_cyc[0]), 0);
    chk("thr.gap01", 64'(pop_cyc[1] - pop_cyc[0]), 64'(GAP));
    chk("thr.gap12", 64'(pop_cyc[2] - pop_cyc[1]), 64'(GAP));
    @(negedge clk);
    chk("thr.inject_count", o_inject_count, 3);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
